mdu_iter: RTL and testbench

//  Iterative multi-cycle RV64M/RV32M multiply/divide unit. It replaces the single-cycle

---
 rtl/mdu_iter.sv | 200 ++++++++++++++++++++
 tb/tb_mdu_iter.sv | 412 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mdu_iter.sv
`default_nettype none
// mdu_iter: iterative RV64M/RV32M multiply/divide unit (shift-add multiplier, restoring divider).
// Revision 1.0

module mdu_iter #(
  parameter int XLEN      = 64,
  parameter bit W_SUPPORT = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      funct3,
  input  logic            is_w,
  input  logic [XLEN-1:0] src1,
  input  logic [XLEN-1:0] src2,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            busy
);

  localparam bit W_EN = W_SUPPORT && (XLEN == 64);
  localparam int CW   = $clog2(XLEN) + 1;
  localparam int AW   = 2 * XLEN + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state;
  logic [CW-1:0]   counter;
  logic [AW-1:0]   acc;
  logic [XLEN-1:0] op_b;
  logic [2:0]      op_f3;
  logic            op_w;
  logic            op_neg_q;
  logic            op_neg_r;

  function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
    logic [XLEN-1:0] r;
    r       = {XLEN{v[31]}};
    r[31:0] = v;
    return r;
  endfunction

  // Request decode, evaluated on the accepting edge
  logic            w_req;
  logic            a_signed;
  logic            b_signed;
  logic [XLEN-1:0] a_ext;
  logic [XLEN-1:0] b_ext;
  logic            a_neg;
  logic            b_neg;
  logic [XLEN-1:0] a_mag;
  logic [XLEN-1:0] b_mag;
  logic [XLEN-1:0] most_neg;
  logic            div_zero;
  logic            div_ovf;
  logic [XLEN-1:0] special_res;
  logic [XLEN-1:0] load_lo;

  always_comb begin
    w_req    = is_w & W_EN;
    a_signed = (funct3 == 3'b001) | (funct3 == 3'b010) | (funct3 == 3'b100) | (funct3 == 3'b110);
    b_signed = (funct3 == 3'b001) | (funct3 == 3'b100) | (funct3 == 3'b110);
    a_ext    = src1;
    b_ext    = src2;
    if (w_req) begin
      a_ext = a_signed ? sext32(src1[31:0]) : XLEN'(src1[31:0]);
      b_ext = b_signed ? sext32(src2[31:0]) : XLEN'(src2[31:0]);
    end
    a_neg    = a_signed & a_ext[XLEN-1];
    b_neg    = b_signed & b_ext[XLEN-1];
    a_mag    = a_neg ? (~a_ext + 1'b1) : a_ext;
    b_mag    = b_neg ? (~b_ext + 1'b1) : b_ext;
    most_neg = w_req ? sext32(32'h8000_0000) : {1'b1, {(XLEN-1){1'b0}}};
    div_zero = funct3[2] & (b_ext == '0);
    div_ovf  = funct3[2] & ~funct3[0] & (a_ext == most_neg) & (b_ext == '1);

    special_res = '0;
    if (div_zero)
      special_res = funct3[1] ? (w_req ? sext32(a_ext[31:0]) : a_ext) : '1;
    else if (div_ovf)
      special_res = funct3[1] ? '0 : a_ext;

    // W divides run 32 iterations, so the dividend starts at the top of the quotient register
    load_lo = (funct3[2] && w_req) ? (a_mag << (XLEN - 32)) : a_mag;
  end

  // One iteration of the datapath
  logic [XLEN:0]   mul_hi;
  logic [AW-1:0]   mul_next;
  logic [XLEN:0]   rem_sh;
  logic [XLEN+1:0] diff;
  logic [AW-1:0]   div_next;
  logic [AW-1:0]   acc_next;

  always_comb begin
    mul_hi   = acc[AW-1:XLEN] + (acc[0] ? {1'b0, op_b} : {(XLEN+1){1'b0}});
    mul_next = {mul_hi, acc[XLEN-1:0]} >> 1;
    rem_sh   = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
    diff     = {1'b0, rem_sh} - {2'b00, op_b};
    div_next = diff[XLEN+1] ? {rem_sh, acc[XLEN-2:0], 1'b0}
                            : {diff[XLEN:0], acc[XLEN-2:0], 1'b1};
    acc_next = op_f3[2] ? div_next : mul_next;
  end

  // Result formation on the final iteration edge, including sign fix-up
  logic [2*XLEN-1:0] prod_s;
  logic [XLEN-1:0]   quot_s;
  logic [XLEN-1:0]   rem_s;
  logic [XLEN-1:0]   div_res;
  logic [XLEN-1:0]   final_res;
  logic [CW-1:0]     last_iter;

  always_comb begin
    prod_s  = op_neg_q ? (~acc_next[2*XLEN-1:0] + 1'b1) : acc_next[2*XLEN-1:0];
    quot_s  = op_neg_q ? (~acc_next[XLEN-1:0] + 1'b1) : acc_next[XLEN-1:0];
    rem_s   = op_neg_r ? (~acc_next[2*XLEN-1:XLEN] + 1'b1) : acc_next[2*XLEN-1:XLEN];
    div_res = op_f3[1] ? rem_s : quot_s;

    final_res = '0;
    if (op_f3[2])
      final_res = op_w ? sext32(div_res[31:0]) : div_res;
    else if (op_f3[1:0] == 2'b00)
      final_res = op_w ? sext32(acc_next[XLEN-1 -: 32]) : prod_s[XLEN-1:0];
    else
      final_res = prod_s[2*XLEN-1:XLEN];

    last_iter = op_w ? CW'(31) : CW'(XLEN - 1);
  end

  assign in_ready = (state == IDLE);
  assign busy     = (state != IDLE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      counter   <= '0;
      acc       <= '0;
      op_b      <= '0;
      op_f3     <= '0;
      op_w      <= 1'b0;
      op_neg_q  <= 1'b0;
      op_neg_r  <= 1'b0;
      out_valid <= 1'b0;
      result    <= '0;
    end else if (flush) begin
      state     <= IDLE;
      counter   <= '0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            op_f3    <= funct3;
            op_w     <= w_req;
            op_b     <= b_mag;
            op_neg_q <= a_neg ^ b_neg;
            op_neg_r <= a_neg;
            acc      <= AW'(load_lo);
            counter  <= '0;
            if (div_zero || div_ovf) begin
              result    <= special_res;
              out_valid <= 1'b1;
              state     <= DONE;
            end else begin
              state <= CALC;
            end
          end
        end
        CALC: begin
          acc <= acc_next;
          if (counter == last_iter) begin
            counter   <= '0;
            result    <= final_res;
            out_valid <= 1'b1;
            state     <= DONE;
          end else begin
            counter <= counter + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mdu_iter.sv
`default_nettype none
// tb_mdu_iter: self-checking bench for mdu_iter with an arithmetic reference model.

module tb_mdu_iter;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  funct3;
  logic        is_w;
  logic [63:0] src1;
  logic [63:0] src2;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] result;
  logic        busy;

  int checks;
  int failures;
  logic [63:0] last_res;

  mdu_iter #(.XLEN(64), .W_SUPPORT(1'b1)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .funct3    (funct3),
    .is_w      (is_w),
    .src1      (src1),
    .src2      (src2),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [63:0] ref_model(input logic [2:0] f3, input logic w,
                                            input logic [63:0] a, input logic [63:0] b);
    logic signed [127:0] x, y, p;
    logic signed [63:0]  sa, sb, sq;
    logic signed [31:0]  wa, wb, wq;
    logic [31:0]         r32;
    logic [63:0]         r;
    r = '0;
    if (w) begin
      wa  = a[31:0];
      wb  = b[31:0];
      r32 = '0;
      case (f3)
        3'b000: r32 = a[31:0] * b[31:0];
        3'b100: begin
          if (wb == 0) r32 = '1;
          else if (a[31:0] == 32'h8000_0000 && wb == -1) r32 = a[31:0];
          else begin wq = wa / wb; r32 = wq; end
        end
        3'b101: r32 = (b[31:0] == 0) ? 32'hFFFF_FFFF : a[31:0] / b[31:0];
        3'b110: begin
          if (wb == 0) r32 = a[31:0];
          else if (a[31:0] == 32'h8000_0000 && wb == -1) r32 = '0;
          else begin wq = wa % wb; r32 = wq; end
        end
        3'b111: r32 = (b[31:0] == 0) ? a[31:0] : a[31:0] % b[31:0];
        default: r32 = '0;
      endcase
      r = {{32{r32[31]}}, r32};
    end else begin
      sa = a;
      sb = b;
      case (f3)
        3'b000: r = a * b;
        3'b001: begin x = sa; y = sb; p = x * y; r = p[127:64]; end
        3'b010: begin x = sa; y = {64'b0, b}; p = x * y; r = p[127:64]; end
        3'b011: begin x = {64'b0, a}; y = {64'b0, b}; p = x * y; r = p[127:64]; end
        3'b100: begin
          if (b == 0) r = '1;
          else if (a == 64'h8000_0000_0000_0000 && sb == -1) r = a;
          else begin sq = sa / sb; r = sq; end
        end
        3'b101: r = (b == 0) ? 64'hFFFF_FFFF_FFFF_FFFF : a / b;
        3'b110: begin
          if (b == 0) r = a;
          else if (a == 64'h8000_0000_0000_0000 && sb == -1) r = '0;
          else begin sq = sa % sb; r = sq; end
        end
        default: r = (b == 0) ? a : a % b;
      endcase
    end
    return r;
  endfunction

  function automatic int exp_lat(input logic [2:0] f3, input logic w,
                                 input logic [63:0] a, input logic [63:0] b);
    logic zero, ovf;
    if (!f3[2]) return w ? 33 : 65;
    zero = w ? (b[31:0] == 0) : (b == 0);
    ovf  = !f3[0] && (w ? (a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF)
                        : (a == 64'h8000_0000_0000_0000 && b == 64'hFFFF_FFFF_FFFF_FFFF));
    return (zero || ovf) ? 1 : (w ? 33 : 65);
  endfunction

  // Presents one request, then waits (bounded) for out_valid without retiring it
  task automatic run_op(input logic [2:0] f3, input logic w, input logic [63:0] a,
                        input logic [63:0] b, output logic [63:0] res, output int lat);
    @(negedge clk);
    in_valid = 1'b1;
    funct3   = f3;
    is_w     = w;
    src1     = a;
    src2     = b;
    @(negedge clk);
    in_valid = 1'b0;
    funct3   = 3'($urandom_range(0, 7));
    is_w     = 1'($urandom_range(0, 1));
    src1     = {$urandom, $urandom};
    src2     = {$urandom, $urandom};
    lat = 1;
    while (!out_valid && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    res = result;
    if (!out_valid) begin
      checks++;
      failures++;
      $display("FAIL timeout f3=%0d w=%0d: out_valid never rose within %0d cycles", f3, w, lat);
    end
  endtask

  task automatic retire();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (in_ready !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0 || result !== 64'h0) begin
      failures++;
      $display("FAIL reset_state: in_ready=%b busy=%b out_valid=%b result=%h, want 1 0 0 0",
               in_ready, busy, out_valid, result);
    end
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_mul();
    logic [63:0] res;
    int lat;
    run_op(3'b000, 1'b0, 64'd7, -64'sd3, res, lat);
    checks++;
    if (res !== 64'hFFFF_FFFF_FFFF_FFEB || lat !== 65) begin
      failures++;
      $display("FAIL mul_7x-3: result=%h lat=%0d, want ffffffffffffffeb lat=65", res, lat);
    end
    retire();
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL mul_retire: in_ready=%b out_valid=%b, want 1 0", in_ready, out_valid);
    end
  endtask

  task automatic test_mulh();
    logic [63:0] res;
    logic [63:0] exp [3];
    int lat;
    exp[0] = 64'h0;
    exp[1] = 64'hFFFF_FFFF_FFFF_FFFE;
    exp[2] = 64'hFFFF_FFFF_FFFF_FFFF;
    for (int i = 0; i < 3; i++) begin
      // order: MULH, MULHU, MULHSU
      run_op((i == 0) ? 3'b001 : (i == 1) ? 3'b011 : 3'b010, 1'b0, '1, '1, res, lat);
      checks++;
      if (res !== exp[i] || lat !== 65) begin
        failures++;
        $display("FAIL mulh_ones_%0d: result=%h lat=%0d, want %h lat=65", i, res, lat, exp[i]);
      end
      retire();
    end
  endtask

  task automatic test_div();
    logic [63:0] res;
    int lat;
    run_op(3'b100, 1'b0, -64'sd7, 64'd2, res, lat);
    checks++;
    if (res !== -64'sd3 || lat !== 65) begin
      failures++;
      $display("FAIL div_-7/2: result=%h lat=%0d, want fffffffffffffffd lat=65", res, lat);
    end
    retire();
    run_op(3'b110, 1'b0, -64'sd7, 64'd2, res, lat);
    checks++;
    if (res !== -64'sd1 || lat !== 65) begin
      failures++;
      $display("FAIL rem_-7%%2: result=%h lat=%0d, want ffffffffffffffff lat=65", res, lat);
    end
    retire();
    run_op(3'b100, 1'b1, 64'h1_8000_0000, 64'd1, res, lat);
    checks++;
    if (res !== 64'hFFFF_FFFF_8000_0000 || lat !== 33) begin
      failures++;
      $display("FAIL divw: result=%h lat=%0d, want ffffffff80000000 lat=33", res, lat);
    end
    retire();
  endtask

  task automatic test_special();
    logic [63:0] res;
    logic [63:0] exp;
    int lat;
    logic [2:0]  f3 [4];
    logic [63:0] a  [4];
    logic [63:0] b  [4];
    f3[0] = 3'b101; a[0] = 64'd1234;                b[0] = 64'd0;
    f3[1] = 3'b111; a[1] = 64'd5;                   b[1] = 64'd0;
    f3[2] = 3'b100; a[2] = 64'h8000_0000_0000_0000; b[2] = '1;
    f3[3] = 3'b110; a[3] = 64'h8000_0000_0000_0000; b[3] = '1;
    for (int i = 0; i < 4; i++) begin
      exp = (i == 0) ? 64'hFFFF_FFFF_FFFF_FFFF : (i == 1) ? 64'd5 :
            (i == 2) ? 64'h8000_0000_0000_0000 : 64'h0;
      run_op(f3[i], 1'b0, a[i], b[i], res, lat);
      checks++;
      if (res !== exp || lat !== 1) begin
        failures++;
        $display("FAIL special_%0d: result=%h lat=%0d, want %h lat=1", i, res, lat, exp);
      end
      retire();
    end
  endtask

  task automatic test_back_to_back();
    logic [63:0] res, a, b, exp;
    int lat;
    bit stable;
    a = {$urandom, $urandom};
    b = {$urandom, $urandom};
    run_op(3'b011, 1'b0, a, b, res, lat);
    exp = ref_model(3'b011, 1'b0, a, b);
    stable = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (result !== exp || in_ready !== 1'b0 || out_valid !== 1'b1) stable = 1'b0;
    end
    checks++;
    if (!stable) begin
      failures++;
      $display("FAIL backpressure_hold: result=%h in_ready=%b out_valid=%b, want %h 0 1",
               result, in_ready, out_valid, exp);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL backpressure_release: in_ready=%b out_valid=%b, want 1 0", in_ready, out_valid);
    end
    a = {$urandom, $urandom};
    b = {32'h0, $urandom};
    in_valid = 1'b1; funct3 = 3'b101; is_w = 1'b0; src1 = a; src2 = b;
    @(negedge clk);
    in_valid = 1'b0;
    checks++;
    if (busy !== 1'b1) begin
      failures++;
      $display("FAIL back_to_back_accept: busy=%b, want 1", busy);
    end
    lat = 1;
    while (!out_valid && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    exp = ref_model(3'b101, 1'b0, a, b);
    checks++;
    if (result !== exp || lat !== exp_lat(3'b101, 1'b0, a, b)) begin
      failures++;
      $display("FAIL back_to_back_divu: result=%h lat=%0d, want %h lat=%0d",
               result, lat, exp, exp_lat(3'b101, 1'b0, a, b));
    end
    last_res = exp;
    retire();
  endtask

  task automatic test_flush_reset();
    logic [63:0] res;
    int lat;
    bit stray;
    @(negedge clk);
    in_valid = 1'b1; funct3 = 3'b000; is_w = 1'b0;
    src1 = {$urandom, $urandom}; src2 = {$urandom, $urandom};
    @(negedge clk);
    in_valid = 1'b0;
    repeat (19) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    checks++;
    if (busy !== 1'b0 || out_valid !== 1'b0 || result !== last_res) begin
      failures++;
      $display("FAIL flush_calc: busy=%b out_valid=%b result=%h, want 0 0 %h",
               busy, out_valid, result, last_res);
    end
    in_valid = 1'b1; flush = 1'b1; funct3 = 3'b100; src2 = 64'd3;
    @(negedge clk);
    in_valid = 1'b0; flush = 1'b0;
    checks++;
    if (busy !== 1'b0 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL flush_idle_accept: busy=%b in_ready=%b, want 0 1", busy, in_ready);
    end
    in_valid = 1'b1; funct3 = 3'b100; is_w = 1'b0;
    src1 = {$urandom, $urandom}; src2 = {32'h0, $urandom} | 64'd1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (39) @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || out_valid !== 1'b0 || result !== 64'h0 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_mid_op: busy=%b out_valid=%b result=%h in_ready=%b, want 0 0 0 1",
               busy, out_valid, result, in_ready);
    end
    @(negedge clk);
    rst = 1'b1;
    stray = 1'b0;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      if (out_valid !== 1'b0 || busy !== 1'b0) stray = 1'b1;
    end
    checks++;
    if (stray) begin
      failures++;
      $display("FAIL no_stray_result: out_valid or busy rose after reset");
    end
    run_op(3'b000, 1'b1, 64'h7FFF_FFFF, 64'd2, res, lat);
    checks++;
    if (res !== 64'hFFFF_FFFF_FFFF_FFFE || lat !== 33) begin
      failures++;
      $display("FAIL mulw_after_reset: result=%h lat=%0d, want fffffffffffffffe lat=33", res, lat);
    end
    retire();
  endtask

  task automatic test_random();
    logic [63:0] res, a, b, exp;
    logic [2:0]  f3;
    logic        w;
    int lat, elat, pick;
    for (int n = 0; n < 40; n++) begin
      f3   = 3'($urandom_range(0, 7));
      w    = (f3 == 3'b000 || f3[2]) ? 1'($urandom_range(0, 1)) : 1'b0;
      pick = $urandom_range(0, 9);
      a    = {$urandom, $urandom};
      b    = {$urandom, $urandom};
      if (pick == 0) b = w ? {$urandom, 32'h0} : 64'h0;
      else if (pick == 1) begin
        a = w ? {$urandom, 32'h8000_0000} : 64'h8000_0000_0000_0000;
        b = w ? {$urandom, 32'hFFFF_FFFF} : 64'hFFFF_FFFF_FFFF_FFFF;
      end else if (pick == 2) begin
        a = 64'($signed(8'($urandom)));
        b = 64'($signed(4'($urandom)));
      end
      exp  = ref_model(f3, w, a, b);
      elat = exp_lat(f3, w, a, b);
      run_op(f3, w, a, b, res, lat);
      checks++;
      if (res !== exp || lat !== elat) begin
        failures++;
        $display("FAIL random_%0d f3=%0d w=%0d a=%h b=%h: result=%h lat=%0d, want %h lat=%0d",
                 n, f3, w, a, b, res, lat, exp, elat);
      end
      retire();
    end
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    last_res  = '0;
    rst       = 1'b0;
    in_valid  = 1'b0;
    funct3    = '0;
    is_w      = 1'b0;
    src1      = '0;
    src2      = '0;
    flush     = 1'b0;
    out_ready = 1'b0;
    test_reset();
    test_mul();
    test_mulh();
    test_div();
    test_special();
    test_back_to_back();
    test_flush_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
